seg7_byte_decoder: RTL and testbench
====================================

// Module: seg7_byte_decoder
// PURPOSE
//  Reverse of the hex-to-7-segment path. Captures a two-digit, active-low segment pair (as driven to the DE1 HEXn pins),
//  waits until it is stable, and decodes it back to a byte. Hands the byte out on a valid/ready port.
//  Used for on-board self-check and debug readback of the displayed value. Flags illegal glyphs.
// PARAMETERS
//  SYNC_STAGES    2   flops in the input synchronizer per bit (>=2)
//  STABLE_CYCLES  16  consecutive unchanged synced cycles required before decode (>=1)
//  EMIT_REPEATS   0   1: re-emit a stable value equal to the last one; 0: suppress repeats
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  seg_lo       in   7  low digit, active-low, bit6=a .. bit0=g
//  seg_hi       in   7  high digit, same encoding
//  out_ready    in   1  consumer accepts byte_out when out_valid&out_ready
//  clear_ovf    in   1  single-cycle pulse, clears overflow
//  byte_out     out  8  {hi_nibble, lo_nibble}
//  out_valid    out  1  byte_out holds an unaccepted value
//  bad_pattern  out  1  1-cycle pulse: stable pattern is not a legal glyph
//  overflow     out  1  sticky: a new stable value was dropped while out_valid was pending
// BEHAVIOUR
//  - One clock; reset is asynchronous, active-low (rst_n).
//  - Reset values: byte_out=0, out_valid=0, bad_pattern=0, overflow=0.
//    Sync flops reset to 7'h7F (blank). Counter=0, last-seen=invalid, FSM=SETTLE.
//  - Glyph table (active-high, before inversion):
//      0=7E  1=30  2=6D  3=79  4=33  5=5B  6=5F  7=70
//      8=7F  9=7B  A=77  b=1F  C=4E  d=3D  E=4F  F=47
//    A digit is legal only if its inverted value matches an entry exactly.
//  - Stability: 14-bit synced word s. If s != s_prev, the counter clears to 0.
//    Otherwise the counter saturates at STABLE_CYCLES.
//    The stable event fires in the single cycle the counter reaches STABLE_CYCLES.
//  - FSM states:
//    - SETTLE: waits for the stable event, then goes to CHECK.
//    - CHECK (1 cycle):
//      - If either digit is illegal: pulse bad_pattern, record last-seen=s, go to ARMED.
//      - Else if s == last-seen and EMIT_REPEATS=0: go to ARMED.
//      - Else: record last-seen.
//        - out_valid=0: load byte_out and set out_valid.
//        - out_valid=1 and not accepted this cycle: drop the value, set overflow.
//        - Go to ARMED.
//    - ARMED: any change of s returns to SETTLE.
//  - Latency: an input step with no further change gives out_valid high exactly
//    SYNC_STAGES+STABLE_CYCLES+2 cycles after the first edge it is sampled on.
//  - Handshake:
//    - out_valid stays high and byte_out stays constant until out_valid&out_ready; out_valid falls the next cycle.
//    - out_ready while out_valid=0 is ignored.
//    - Acceptance in the same cycle as CHECK frees the slot first, so the new byte loads with no overflow.
//  - overflow: clear_ovf clears it unless a set occurs in the same cycle (set wins).
//  - Glitch shorter than STABLE_CYCLES: no emission, no bad_pattern.
//  - rst_n assert mid-operation: all state returns to reset values immediately; no partial output survives.
// STRUCTURE
//  - Package seg7_pkg:
//    - SEG_BLANK=7'h7F (active-low blank)
//    - 16-entry glyph localparam array
//    - function seg7_decode(input [6:0] seg_n) returns {legal, nibble[3:0]}
//    - FSM state enum
//  - One sub-module seg7_digit_decode: combinational 7->{legal, nibble}, instantiated twice.
//    Synchronizer, counter, FSM and handshake live in the top module.
// TESTING
//  1. Reset, then hi=~30, lo=~77 held. byte_out=8'h1A, out_valid rises at SYNC+STABLE+2; ready=1 clears it next cycle.
//  2. Same value held after accept, EMIT_REPEATS=0. Change to ~7E/~7E, then back to 1A.
//     Out: 00, then 1A again; no spurious repeat while held.
//  3. lo toggles ~5F/~7F every 4 cycles (STABLE=16). No out_valid, no bad_pattern.
//     Hold ~5F: byte low nibble 6.
//  4. lo=~7'h01 (lone g), stable. bad_pattern pulses exactly 1 cycle; out_valid stays 0; byte_out unchanged.
//  5. out_ready=0: emit 12, then a stable 34. byte_out stays 12 and overflow=1.
//     clear_ovf clears it; accept, then 34 is not emitted (dropped).
//  6. rst_n low for 1 cycle mid-SETTLE and once with out_valid=1. All outputs 0 asynchronously; the sequence restarts cleanly.

Source files
------------

// File: rtl/seg7_byte_decoder_pkg.sv
// seg7_pkg: glyph table, blank code, per-digit decode function and FSM states for the segment readback path
package seg7_pkg;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] GLYPH [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };
   typedef enum logic [1:0] {SETTLE, CHECK, ARMED} state_t;
   function automatic logic [4:0] seg7_decode(input logic [6:0] seg_n);
      logic [4:0] r;
      r = 5'd0;
      for (int i = 0; i < 16; i++)
         if (~seg_n == GLYPH[i]) r = {1'b1, 4'(i)};
      return r;
   endfunction
endpackage

// File: rtl/seg7_digit_decode.sv
// seg7_digit_decode: active-low 7-segment digit to {legal, nibble}
module seg7_digit_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic       legal,
   output logic [3:0] nibble
);
   assign {legal, nibble} = seg7_decode(seg_n);
endmodule

// File: rtl/seg7_byte_decoder.sv
// seg7_byte_decoder: synchronizes a two-digit segment pair, waits for stability, decodes it to a byte on valid/ready
module seg7_byte_decoder
   import seg7_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 16,
   parameter int EMIT_REPEATS  = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg_lo,
   input  logic [6:0] seg_hi,
   input  logic       out_ready,
   input  logic       clear_ovf,
   output logic [7:0] byte_out,
   output logic       out_valid,
   output logic       bad_pattern,
   output logic       overflow
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
   logic [13:0] sync [SYNC_STAGES];
   logic [13:0] s, s_prev, last;
   logic [CW-1:0] cnt;
   logic [3:0] nib_hi, nib_lo;
   logic ok_hi, ok_lo, last_vld, fired, changed, stable;
   logic load, drop, bad, rec;
   state_t state, nxt;
   assign s = sync[SYNC_STAGES-1];
   assign changed = s != s_prev;
   // fired remembers saturation so the stable event is a single-cycle pulse
   assign stable = cnt == CMAX && !fired;
   seg7_digit_decode u_hi (.seg_n(s[13:7]), .legal(ok_hi), .nibble(nib_hi));
   seg7_digit_decode u_lo (.seg_n(s[6:0]), .legal(ok_lo), .nibble(nib_lo));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= {SEG_BLANK, SEG_BLANK};
         s_prev <= {SEG_BLANK, SEG_BLANK};
         cnt    <= '0;
         fired  <= 1'b0;
      end else begin
         sync[0] <= {seg_hi, seg_lo};
         for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
         s_prev <= s;
         cnt    <= changed ? '0 : (cnt == CMAX ? cnt : cnt + 1'b1);
         fired  <= cnt == CMAX;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SETTLE;
      else        state <= nxt;
   end
   always_comb begin
      nxt  = state;
      load = 1'b0;
      drop = 1'b0;
      bad  = 1'b0;
      rec  = 1'b0;
      case (state)
         SETTLE: nxt = stable ? CHECK : SETTLE;
         CHECK: begin
            nxt = changed ? SETTLE : ARMED;
            if (!(ok_hi && ok_lo)) begin
               bad = 1'b1;
               rec = 1'b1;
            end else if (EMIT_REPEATS != 0 || !last_vld || s != last) begin
               rec  = 1'b1;
               load = !out_valid || out_ready;
               drop = !load;
            end
         end
         ARMED:   nxt = changed ? SETTLE : ARMED;
         default: nxt = SETTLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_out    <= 8'h00;
         out_valid   <= 1'b0;
         bad_pattern <= 1'b0;
         overflow    <= 1'b0;
         last        <= '0;
         last_vld    <= 1'b0;
      end else begin
         out_valid   <= load || (out_valid && !out_ready);
         bad_pattern <= bad;
         overflow    <= drop || (overflow && !clear_ovf);
         if (load) byte_out <= {nib_hi, nib_lo};
         if (rec) begin
            last     <= s;
            last_vld <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_seg7_byte_decoder.sv
// tb_seg7_byte_decoder: directed scoreboard bench for the segment readback decoder
module tb_seg7_byte_decoder;
   logic clk = 1'b0;
   logic rst_n, out_ready, clear_ovf;
   logic [6:0] seg_lo, seg_hi;
   logic [7:0] byte_out;
   logic out_valid, bad_pattern, overflow;
   logic [6:0] g [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };
   logic [7:0] q [$];
   int checks = 0, errors = 0;
   int bad_cnt = 0, bad_run = 0, bad_run_max = 0, rise_cnt = 0;
   int b0, r0;
   logic ov_d = 1'b0;
   always #5 clk = ~clk;
   seg7_byte_decoder dut (
      .clk(clk), .rst_n(rst_n), .seg_lo(seg_lo), .seg_hi(seg_hi),
      .out_ready(out_ready), .clear_ovf(clear_ovf), .byte_out(byte_out),
      .out_valid(out_valid), .bad_pattern(bad_pattern), .overflow(overflow)
   );
   always @(negedge clk) begin
      bad_run = bad_pattern ? bad_run + 1 : 0;
      if (bad_run > bad_run_max) bad_run_max = bad_run;
      if (bad_pattern && bad_run == 1) bad_cnt++;
      if (out_valid && !ov_d) rise_cnt++;
      ov_d = out_valid;
   end
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic set_in(input logic [3:0] hi, input logic [3:0] lo);
      seg_hi = ~g[hi];
      seg_lo = ~g[lo];
   endtask
   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_timeout"}, {7'b0, out_valid}, 8'h01);
   endtask
   task automatic accept(input string tag);
      logic [7:0] e;
      chk({tag, "_q"}, {7'b0, q.size() != 0}, 8'h01);
      e = q.size() != 0 ? q.pop_front() : 8'hXX;
      chk({tag, "_byte"}, byte_out, e);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_fall"}, {7'b0, out_valid}, 8'h00);
   endtask
   task automatic async_reset(input string tag);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_byte"}, byte_out, 8'h00);
      chk({tag, "_valid"}, {7'b0, out_valid}, 8'h00);
      chk({tag, "_ovf"}, {7'b0, overflow}, 8'h00);
      q.delete();
      @(negedge clk);
   endtask
   initial begin
      rst_n = 1'b0;
      out_ready = 1'b0;
      clear_ovf = 1'b0;
      set_in(4'h1, 4'hA);
      cyc(2);
      chk("rst_byte", byte_out, 8'h00);
      chk("rst_valid", {7'b0, out_valid}, 8'h00);
      chk("rst_bad", {7'b0, bad_pattern}, 8'h00);
      chk("rst_ovf", {7'b0, overflow}, 8'h00);
      // test 1: latency from the first sampling edge is 2+16+2
      rst_n = 1'b1;
      q.push_back(8'h1A);
      cyc(20);
      chk("lat_early", {7'b0, out_valid}, 8'h00);
      cyc(1);
      chk("lat_hit", {7'b0, out_valid}, 8'h01);
      accept("t1");
      // test 2: repeats suppressed, new values emitted
      r0 = rise_cnt;
      cyc(40);
      chk("t2_hold", {7'b0, out_valid}, 8'h00);
      chk("t2_rise", 8'(rise_cnt - r0), 8'h00);
      set_in(4'h0, 4'h0);
      q.push_back(8'h00);
      wait_valid("t2a");
      accept("t2a");
      set_in(4'h1, 4'hA);
      q.push_back(8'h1A);
      wait_valid("t2b");
      accept("t2b");
      cyc(40);
      chk("t2_hold2", {7'b0, out_valid}, 8'h00);
      // test 3: glitches shorter than the stability window
      b0 = bad_cnt;
      r0 = rise_cnt;
      for (int i = 0; i < 10; i++) begin
         set_in(4'h1, 4'h6);
         cyc(4);
         set_in(4'h1, 4'h8);
         cyc(4);
      end
      chk("t3_rise", 8'(rise_cnt - r0), 8'h00);
      chk("t3_bad", 8'(bad_cnt - b0), 8'h00);
      set_in(4'h1, 4'h6);
      q.push_back(8'h16);
      wait_valid("t3");
      accept("t3");
      // test 4: illegal glyph
      b0 = bad_cnt;
      r0 = rise_cnt;
      seg_lo = ~7'h01;
      cyc(40);
      chk("t4_bad", 8'(bad_cnt - b0), 8'h01);
      chk("t4_width", 8'(bad_run_max), 8'h01);
      chk("t4_rise", 8'(rise_cnt - r0), 8'h00);
      chk("t4_byte", byte_out, 8'h16);
      // test 5: overflow while a byte is pending
      set_in(4'h1, 4'h2);
      q.push_back(8'h12);
      wait_valid("t5");
      chk("t5_ovf0", {7'b0, overflow}, 8'h00);
      set_in(4'h3, 4'h4);
      cyc(40);
      chk("t5_ovf", {7'b0, overflow}, 8'h01);
      chk("t5_keep", byte_out, 8'h12);
      clear_ovf = 1'b1;
      cyc(1);
      clear_ovf = 1'b0;
      chk("t5_clr", {7'b0, overflow}, 8'h00);
      accept("t5");
      cyc(40);
      chk("t5_dropped", {7'b0, out_valid}, 8'h00);
      // test 6: asynchronous reset mid-settle and with a byte pending
      set_in(4'h5, 4'h6);
      cyc(5);
      async_reset("t6a");
      rst_n = 1'b1;
      q.push_back(8'h56);
      cyc(20);
      chk("t6_early", {7'b0, out_valid}, 8'h00);
      cyc(1);
      chk("t6_hit", {7'b0, out_valid}, 8'h01);
      chk("t6_byte", byte_out, 8'h56);
      set_in(4'h7, 4'h8);
      async_reset("t6b");
      rst_n = 1'b1;
      q.push_back(8'h78);
      wait_valid("t6c");
      accept("t6c");
      chk("q_empty", 8'(q.size()), 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
